// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: selects PC+4 / jump / alternate target,
// buffers redirects across stalls and flags fetch flushes. Option macro: PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        reg_jump_req,
    input  logic [31:0] reg_target,
    input  logic        jump_req,
    input  logic [25:0] jump_index,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic [27:0] jump_field,
    output logic [31:0] alt_target,
    output logic        pc_write,
    output logic        flush,
    output logic        pending
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned IDX_W = 26;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_JUMP = 2'd1;
    localparam logic [1:0] SEL_ALT  = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_next;
    logic               flush_q;

    logic               pend_q;
    logic               pend_jump_q;
    logic [IDX_W-1:0]   pend_index_q;
    logic [PC_W-1:0]    pend_alt_q;

    logic               active;
    logic               live_any;
    logic               live_jump;
    logic [PC_W-1:0]    live_alt_target;
    logic               capture;
    logic               apply;

    // Live request decode with fixed priority: register jump > jump > branch.
    always_comb begin
        active          = (state != ST_HOLD);
        live_any        = reg_jump_req | jump_req | branch_req;
        live_jump       = ~reg_jump_req & jump_req;
        live_alt_target = reg_jump_req ? reg_target : branch_target;
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    // Every live redirect is parked first so the delay-slot instruction executes.
    always_comb begin
        capture = active & ~pend_q & live_any;
        apply   = active & ~stall & pend_q;
    end
`else
    // Live redirects apply at once; only stalled ones are parked.
    always_comb begin
        capture = active & stall & ~pend_q & live_any;
        apply   = active & ~stall & (pend_q | live_any);
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HOLD;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
        end
    end

    // Next-state logic; the flush counter freezes while stalled.
    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        case (state)
            ST_HOLD: begin
                state_next = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                if (apply) begin
                    state_next = ST_FLUSH;
                    cnt_next   = CNT_W'(FLUSH_CYCLES);
                end else if ((state == ST_FLUSH) && !stall) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
        endcase
    end

    // Mux select and mux data inputs; HOLD drives everything to zero.
    always_comb begin
        pc_sel     = SEL_SEQ;
        jump_field = '0;
        alt_target = '0;
        pc_write   = 1'b0;
        if (active) begin
            pc_write   = ~stall;
            jump_field = {(pend_q ? pend_index_q : jump_index), 2'b00};
            alt_target = pend_q ? pend_alt_q : live_alt_target;
            if (pend_q) begin
                pc_sel = pend_jump_q ? SEL_JUMP : SEL_ALT;
            end
`ifdef PC_SEQ_DELAY_SLOT_EN
            else begin
                pc_sel = SEL_SEQ;
            end
`else
            else if (live_any) begin
                pc_sel = live_jump ? SEL_JUMP : SEL_ALT;
            end
`endif
        end
    end

    // Next PC is exactly what the external mux produces for pc_sel.
    always_comb begin
        case (pc_sel)
            SEL_JUMP: pc_next = {pc_q[31:28], jump_field};
            SEL_ALT:  pc_next = alt_target;
            default:  pc_next = pc_q + PC_W'(4);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            if (pc_write) begin
                pc_q <= pc_next;
            end
            flush_q <= (state_next == ST_FLUSH);
        end
    end

    // Pending redirect buffer: kind plus both candidate targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= 1'b0;
            pend_jump_q  <= 1'b0;
            pend_index_q <= '0;
            pend_alt_q   <= '0;
        end else if (capture) begin
            pend_q       <= 1'b1;
            pend_jump_q  <= live_jump;
            pend_index_q <= jump_index;
            pend_alt_q   <= live_alt_target;
        end else if (apply) begin
            pend_q <= 1'b0;
        end
    end

    assign pc      = pc_q;
    assign flush   = flush_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, async-reset corner case,
// and randomized traffic checked against a queue-based reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          FLUSH_N = 2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        reg_jump_req;
    logic [31:0] reg_target;
    logic        jump_req;
    logic [25:0] jump_index;
    logic        branch_req;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic [27:0] jump_field;
    logic [31:0] alt_target;
    logic        pc_write;
    logic        flush;
    logic        pending;

    pc_sequencer #(
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FLUSH_N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .reg_jump_req  (reg_jump_req),
        .reg_target    (reg_target),
        .jump_req      (jump_req),
        .jump_index    (jump_index),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_sel        (pc_sel),
        .jump_field    (jump_field),
        .alt_target    (alt_target),
        .pc_write      (pc_write),
        .flush         (flush),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        stall;
        logic        rjr;
        logic [31:0] rt;
        logic        jr;
        logic [25:0] ji;
        logic        br;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic [1:0]  e_sel;
        logic [31:0] e_tgt;
        logic        e_wr;
        logic        e_fl;
        logic        e_pd;
    } vec_t;

    typedef struct {
        bit          is_jump;
        logic [25:0] idx;
        logic [31:0] tgt;
    } redir_t;

    // Reference model: PC, buffered redirect queue, remaining flush cycles.
    bit          m_hold;
    logic [31:0] m_pc;
    redir_t      m_pend[$];
    int          m_flush;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic rjr, input logic [31:0] rt,
                                input logic jr, input logic [25:0] ji, input logic br,
                                input logic [31:0] bt, input logic [31:0] e_pc,
                                input logic [1:0] e_sel, input logic [31:0] e_tgt,
                                input logic e_wr, input logic e_fl, input logic e_pd);
        vec_t v;
        v.stall = s;   v.rjr = rjr; v.rt = rt; v.jr = jr; v.ji = ji; v.br = br; v.bt = bt;
        v.e_pc = e_pc; v.e_sel = e_sel; v.e_tgt = e_tgt;
        v.e_wr = e_wr; v.e_fl = e_fl; v.e_pd = e_pd;
        return v;
    endfunction

    task automatic drive(input logic s, input logic rjr, input logic [31:0] rt, input logic jr,
                         input logic [25:0] ji, input logic br, input logic [31:0] bt);
        stall = s; reg_jump_req = rjr; reg_target = rt;
        jump_req = jr; jump_index = ji; branch_req = br; branch_target = bt;
    endtask

    task automatic model_reset();
        m_hold  = 1'b1;
        m_pc    = RST_PC;
        m_pend.delete();
        m_flush = 0;
    endtask

    // Effective request: buffered one wins, else highest-priority live one.
    task automatic model_eff(output int kind, output logic [25:0] idx, output logic [31:0] tgt);
        kind = 0; idx = jump_index; tgt = 32'h0;
        if (m_pend.size() > 0) begin
            kind = m_pend[0].is_jump ? 1 : 2;
            idx  = m_pend[0].idx;
            tgt  = m_pend[0].tgt;
        end else if (reg_jump_req) begin
            kind = 2; tgt = reg_target;
        end else if (jump_req) begin
            kind = 1; idx = jump_index;
        end else if (branch_req) begin
            kind = 2; tgt = branch_target;
        end
    endtask

    task automatic model_check();
        int          kind;
        logic [25:0] idx;
        logic [31:0] tgt;
        model_eff(kind, idx, tgt);
        chk("m pc", pc, m_pc);
        chk("m flush", 32'(flush), 32'(m_flush > 0));
        chk("m pending", 32'(pending), 32'(m_pend.size() > 0));
        if (m_hold) begin
            chk("m hold pc_write", 32'(pc_write), 32'h0);
            chk("m hold pc_sel", 32'(pc_sel), 32'h0);
            chk("m hold jump_field", 32'(jump_field), 32'h0);
            chk("m hold alt_target", alt_target, 32'h0);
        end else begin
            chk("m pc_write", 32'(pc_write), 32'(!stall));
            if (!stall) chk("m pc_sel", 32'(pc_sel), 32'(kind));
            if (kind == 1) chk("m jump_field", 32'(jump_field), 32'({idx, 2'b00}));
            if (kind == 2) chk("m alt_target", alt_target, tgt);
        end
    endtask

    task automatic model_step();
        int          kind;
        logic [25:0] idx;
        logic [31:0] tgt;
        redir_t      r;
        if (m_hold) begin
            m_hold = 1'b0;
            return;
        end
        model_eff(kind, idx, tgt);
        if (stall) begin
            if (m_pend.size() == 0 && kind != 0) begin
                r.is_jump = (kind == 1); r.idx = idx; r.tgt = tgt;
                m_pend.push_back(r);
            end
        end else if (kind != 0) begin
            m_pc    = (kind == 1) ? {m_pc[31:28], idx, 2'b00} : tgt;
            m_flush = FLUSH_N;
            m_pend.delete();
        end else begin
            m_pc = m_pc + 32'd4;
            if (m_flush > 0) m_flush--;
        end
    endtask

    task automatic row_check(input vec_t v, input int i);
        chk($sformatf("row%0d pc", i), pc, v.e_pc);
        chk($sformatf("row%0d pc_write", i), 32'(pc_write), 32'(v.e_wr));
        chk($sformatf("row%0d flush", i), 32'(flush), 32'(v.e_fl));
        chk($sformatf("row%0d pending", i), 32'(pending), 32'(v.e_pd));
        if (!v.stall) begin
            chk($sformatf("row%0d pc_sel", i), 32'(pc_sel), 32'(v.e_sel));
            if (v.e_sel == 2'd1) chk($sformatf("row%0d jump_field", i), 32'(jump_field), 32'(v.e_tgt[27:0]));
            if (v.e_sel == 2'd2) chk($sformatf("row%0d alt_target", i), alt_target, v.e_tgt);
        end
    endtask

    // One clock cycle: drive at edge+1, check at edge+3, advance model at the edge.
    task automatic cycle(input logic s, input logic rjr, input logic [31:0] rt, input logic jr,
                         input logic [25:0] ji, input logic br, input logic [31:0] bt);
        drive(s, rjr, rt, jr, ji, br, bt);
        #2;
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " pc"}, pc, RST_PC);
        chk({tag, " pc_sel"}, 32'(pc_sel), 32'h0);
        chk({tag, " pc_write"}, 32'(pc_write), 32'h0);
        chk({tag, " flush"}, 32'(flush), 32'h0);
        chk({tag, " pending"}, 32'(pending), 32'h0);
        chk({tag, " jump_field"}, 32'(jump_field), 32'h0);
        chk({tag, " alt_target"}, alt_target, 32'h0);
    endtask

    // Assert reset mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Directed table (RESET_PC = 0040_0000, FLUSH_CYCLES = 2).
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0040_0000,2'd0,32'h0,         0,0,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0040_0000,2'd0,32'h0,         1,0,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0040_0004,2'd0,32'h0,         1,0,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0040_0008,2'd0,32'h0,         1,0,0));
        tbl.push_back(mk(0,1,32'h1000_0000,0,26'h0,0,32'h0, 32'h0040_000C,2'd2,32'h1000_0000, 1,0,0));
        tbl.push_back(mk(0,0,32'h0,1,26'h100,0,32'h0, 32'h1000_0000,2'd1,32'h0000_0400, 1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h1000_0400,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h1000_0404,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h1000_0408,2'd0,32'h0,         1,0,0));
        tbl.push_back(mk(0,1,32'h0000_2000,1,26'h3FF_FFFF,1,32'h0000_3000, 32'h1000_040C,2'd2,32'h0000_2000, 1,0,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_2000,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_2004,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_2008,2'd0,32'h0,         1,0,0));
        tbl.push_back(mk(1,0,32'h0,0,26'h0,1,32'h0000_0800, 32'h0000_200C,2'd0,32'h0, 0,0,0));
        tbl.push_back(mk(1,0,32'h0,0,26'h0,1,32'h0000_0800, 32'h0000_200C,2'd0,32'h0, 0,0,1));
        tbl.push_back(mk(1,0,32'h0,0,26'h0,1,32'h0000_0800, 32'h0000_200C,2'd0,32'h0, 0,0,1));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,1,32'h0000_0800, 32'h0000_200C,2'd2,32'h0000_0800, 1,0,1));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_0800,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_0804,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_0808,2'd0,32'h0,         1,0,0));
        tbl.push_back(mk(0,1,32'hFFFF_FFF8,0,26'h0,0,32'h0, 32'h0000_080C,2'd2,32'hFFFF_FFF8, 1,0,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'hFFFF_FFF8,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'hFFFF_FFFC,2'd0,32'h0,         1,1,0));
        tbl.push_back(mk(0,0,32'h0,0,26'h0,0,32'h0, 32'h0000_0000,2'd0,32'h0,         1,0,0));

        // Reset with live requests present: outputs still at reset values.
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1, 26'h155, 1'b1, 32'h0BAD_0000);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].rjr, tbl[i].rt, tbl[i].jr, tbl[i].ji, tbl[i].br, tbl[i].bt);
            #2;
            model_check();
            row_check(tbl[i], i);
            @(posedge clk);
            model_step();
            #1;
        end

        // Reset during FLUSH while a redirect is buffered.
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_4000);
        cycle(1'b1, 1'b1, 32'h0000_5000, 1'b0, 26'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        #2;
        chk("pre-reset pc", pc, 32'h0000_4000);
        chk("pre-reset flush", 32'(flush), 32'h1);
        chk("pre-reset pending", 32'(pending), 32'h1);
        async_reset("mid-flush reset");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic        s, rjr, jr, br;
            logic [31:0] rt, bt;
            logic [25:0] ji;
            s   = ($urandom_range(0, 2) == 0);
            rjr = ($urandom_range(0, 7) == 0);
            jr  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 5) == 0);
            rt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : $urandom;
            bt  = $urandom;
            ji  = 26'($urandom);
            cycle(s, rjr, rt, jr, ji, br, bt);
            if (n % 700 == 699) async_reset("random reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
